// File: rtl/wptr_full_ctl.sv
// Async FIFO write-side controller: rptr sync, write pointers, full/level status.
// Optional level/almost-full logic is built only when WPTR_AFULL_EN is defined.
module wptr_full_ctl #(
    parameter int ADDRSIZE     = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 12
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr,
    input  logic                woverflow_clr,
    output logic                wen,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow
);

    localparam int PW = ADDRSIZE + 1;

    if (SYNC_STAGES < 2 || AFULL_THRESH < 1 ||
        AFULL_THRESH > (1 << ADDRSIZE)) begin : g_bad_param
        $error("wptr_full_ctl: illegal parameter value");
    end

    logic [ADDRSIZE:0] sync_q [SYNC_STAGES];
    logic [ADDRSIZE:0] sync_d [SYNC_STAGES];
    logic [ADDRSIZE:0] wq_rptr;
    logic [ADDRSIZE:0] wbin_q, wbin_d;
    logic [ADDRSIZE:0] wptr_q, wptr_d;
    logic              wfull_q, wfull_d;
    logic              wovf_q, wovf_d;

    assign wq_rptr = sync_q[SYNC_STAGES-1];

    // Gating with wrst_n keeps the memory write enable low throughout reset.
    assign wen = winc & ~wfull_q & wrst_n;

    always_comb begin
        sync_d[0] = rptr;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        wbin_d  = wbin_q + PW'(wen);
        wptr_d  = (wbin_d >> 1) ^ wbin_d;
        wfull_d = (wptr_d == {~wq_rptr[ADDRSIZE:ADDRSIZE-1],
                              wq_rptr[ADDRSIZE-2:0]});
        wovf_d  = wovf_q;
        if (winc & wfull_q) begin
            wovf_d = 1'b1;
        end else if (woverflow_clr) begin
            wovf_d = 1'b0;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            wbin_q  <= '0;
            wptr_q  <= '0;
            wfull_q <= 1'b0;
            wovf_q  <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            wbin_q  <= wbin_d;
            wptr_q  <= wptr_d;
            wfull_q <= wfull_d;
            wovf_q  <= wovf_d;
        end
    end

    assign waddr     = wbin_q[ADDRSIZE-1:0];
    assign wptr      = wptr_q;
    assign wfull     = wfull_q;
    assign woverflow = wovf_q;

`ifdef WPTR_AFULL_EN
    localparam logic [ADDRSIZE:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] wlevel_q, wlevel_d;
    logic              wafull_q, wafull_d;

    always_comb begin
        for (int i = 0; i < PW; i++) begin
            rbin_s[i] = ^(wq_rptr >> i);
        end
        wlevel_d = wbin_d - rbin_s;
        wafull_d = (wlevel_d >= AFULL_LVL);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wlevel_q <= '0;
            wafull_q <= 1'b0;
        end else begin
            wlevel_q <= wlevel_d;
            wafull_q <= wafull_d;
        end
    end

    assign wlevel = wlevel_q;
    assign wafull = wafull_q;
`else
    assign wlevel = '0;
    assign wafull = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full_ctl.sv
// Randomized bench for wptr_full_ctl against a count-based FIFO model.
// Expects wlevel/wafull active only when WPTR_AFULL_EN is defined.
module tb_wptr_full_ctl;

    localparam int AW = 4;
    localparam int SS = 2;
`ifdef WPTR_AFULL_EN
    localparam bit AF_EN = 1'b1;
`else
    localparam bit AF_EN = 1'b0;
`endif

    logic          wclk = 1'b0;
    logic          wrst_n = 1'b0;
    logic          winc = 1'b0;
    logic [AW:0]   rptr = '0;
    logic          woverflow_clr = 1'b0;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic          wfull, wafull, woverflow;
    logic [AW:0]   wlevel;

    wptr_full_ctl #(.ADDRSIZE(AW), .SYNC_STAGES(SS), .AFULL_THRESH(12)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .rptr(rptr),
        .woverflow_clr(woverflow_clr), .wen(wen), .waddr(waddr),
        .wptr(wptr), .wfull(wfull), .wafull(wafull), .wlevel(wlevel),
        .woverflow(woverflow)
    );

    always #5 wclk = ~wclk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: total writes accepted, reads as seen through a SS-edge delay.
    int m_w = 0;
    int rcnt = 0;
    int rq[$] = '{0, 0};
    int m_lvl = 0;
    bit m_full = 1'b0;
    bit m_ovf = 1'b0;

    function automatic logic [AW:0] gray(input int v);
        logic [AW:0] b;
        b = v[AW:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    always @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            m_w = 0; m_lvl = 0; m_full = 0; m_ovf = 0;
            rq = '{0, 0};
        end else begin
            int stale;
            bit acc;
            acc = winc && !m_full;
            if (winc && m_full) m_ovf = 1;
            else if (woverflow_clr) m_ovf = 0;
            stale = rq[0];
            void'(rq.pop_front());
            rq.push_back(rcnt);
            if (acc) m_w++;
            m_lvl = m_w - stale;
            m_full = (m_lvl == 16);
        end
    end

    always @(negedge wclk) begin
        if (chk_en) begin
            chk("wen", 32'(wen), 32'(wrst_n && winc && !m_full));
            chk("waddr", 32'(waddr), 32'(m_w % 16));
            chk("wptr", 32'(wptr), 32'(gray(m_w)));
            chk("wfull", 32'(wfull), 32'(m_full));
            chk("wafull", 32'(wafull), 32'(AF_EN && m_lvl >= 12));
            chk("wlevel", 32'(wlevel), AF_EN ? 32'(m_lvl) : 32'd0);
            chk("woverflow", 32'(woverflow), 32'(m_ovf));
        end
    end

    task automatic cyc(input bit inc, input bit clr);
        @(negedge wclk);
        #2;
        winc = inc;
        woverflow_clr = clr;
        rptr = gray(rcnt);
        @(posedge wclk);
        #1;
    endtask

    initial begin
        bit seen_top;
        bit seen_wrap;
        #22;
        wrst_n = 1'b1;
        chk_en = 1'b1;
        chk("rst_wptr", 32'(wptr), 32'd0);
        chk("rst_wlevel", 32'(wlevel), 32'd0);

        for (int i = 1; i <= 16; i++) begin
            cyc(1, 0);
            if (i == 11) chk("fill11_wafull", 32'(wafull), 32'd0);
            if (i == 12) chk("fill12_wafull", 32'(wafull), 32'(AF_EN));
            if (i == 15) chk("fill15_wfull", 32'(wfull), 32'd0);
        end
        chk("fill_wfull", 32'(wfull), 32'd1);
        chk("fill_wlevel", 32'(wlevel), AF_EN ? 32'd16 : 32'd0);
        chk("fill_wptr", 32'(wptr), 32'b11000);

        cyc(1, 0);
        chk("ovf_wen", 32'(wen), 32'd0);
        chk("ovf_wptr", 32'(wptr), 32'b11000);
        chk("ovf_waddr", 32'(waddr), 32'd0);
        chk("ovf_set", 32'(woverflow), 32'd1);
        cyc(0, 1);
        chk("ovf_clr", 32'(woverflow), 32'd0);
        cyc(1, 1);
        chk("ovf_set_wins", 32'(woverflow), 32'd1);

        rcnt = 1;
        cyc(0, 0);
        chk("drain_k", 32'(wfull), 32'd1);
        cyc(0, 0);
        chk("drain_k1", 32'(wfull), 32'd1);
        cyc(0, 0);
        chk("drain_k2", 32'(wfull), 32'd0);
        chk("drain_lvl", 32'(wlevel), AF_EN ? 32'd15 : 32'd0);

        @(posedge wclk);
        #3;
        winc = 1'b0;
        wrst_n = 1'b0;
        rcnt = 0;
        #1;
        chk("arst_wptr", 32'(wptr), 32'd0);
        chk("arst_waddr", 32'(waddr), 32'd0);
        chk("arst_wfull", 32'(wfull), 32'd0);
        chk("arst_ovf", 32'(woverflow), 32'd0);
        chk("arst_wen", 32'(wen), 32'd0);
        @(negedge wclk);
        #1;
        wrst_n = 1'b1;

        seen_top = 0;
        seen_wrap = 0;
        for (int n = 0; n < 40; n++) begin
            rcnt = (n > 0) ? n - 1 : 0;
            cyc(1, 0);
            chk("wrap_wfull", 32'(wfull), 32'd0);
            if (wptr == 5'b10000) seen_top = 1;
            if (seen_top && wptr == 5'b00000) seen_wrap = 1;
        end
        chk("wrap_top", 32'(seen_top), 32'd1);
        chk("wrap_zero", 32'(seen_wrap), 32'd1);

        for (int n = 0; n < 600; n++) begin
            if (rcnt < m_w && ($urandom % 2) == 0) rcnt++;
            cyc(($urandom % 4) != 0, ($urandom % 8) == 0);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule
